// File: rtl/eeg_sample_ingest.sv
// eeg_sample_ingest: converts raw ADC EEG samples to 15-bit signed words and streams one epoch into intermediate-result memory.
module eeg_sample_ingest #(
  parameter int NUM_SAMPLES = 3840,
  parameter int BASE_ADDR   = 0,
  parameter int ADC_BITS    = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                sample_valid,
  input  logic [ADC_BITS-1:0] sample_data,
  output logic                mem_wr_req,
  output logic [15:0]         mem_wr_addr,
  output logic [14:0]         mem_wr_data,
  input  logic                mem_wr_gnt,
  output logic                capturing,
  output logic [11:0]         sample_count,
  output logic                epoch_done,
  output logic                overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [11:0] NUM_W = 12'(NUM_SAMPLES);
  localparam logic [15:0] BASE_W = 16'(BASE_ADDR);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

  if (BASE_ADDR + NUM_SAMPLES - 1 >= 63488) begin : g_addr_chk
    $error("eeg_sample_ingest: epoch does not fit below address 63488");
  end
  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 4095) begin : g_num_chk
    $error("eeg_sample_ingest: NUM_SAMPLES must fit the 12-bit sample counter");
  end
  if (ADC_BITS < 15) begin : g_adc_chk
    $error("eeg_sample_ingest: ADC_BITS must be at least 15");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
    $error("eeg_sample_ingest: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (ADC_BITS > 15) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^sample_data[ADC_BITS-16:0];
  end

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state;
  logic [14:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fifo_cnt, fifo_cnt_next;
  logic [11:0] acc_cnt;
  logic [14:0] conv;
  logic pop, push_try, full, push;

  // Offset-binary to two's complement is an MSB flip; the arithmetic shift keeps the top 15 bits.
  assign conv = {~sample_data[ADC_BITS-1], sample_data[ADC_BITS-2 -: 14]};
  assign pop = mem_wr_req & mem_wr_gnt;
  assign full = fifo_cnt == DEPTH_W;
  assign push_try = state == COLLECT && sample_valid && acc_cnt < NUM_W;
  assign push = push_try && (!full || pop);
  assign fifo_cnt_next = fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign mem_wr_data = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      fifo_mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
      acc_cnt <= '0;
      sample_count <= '0;
      mem_wr_addr <= '0;
      mem_wr_req <= 1'b0;
      capturing <= 1'b0;
      epoch_done <= 1'b0;
      overflow <= 1'b0;
    end else if (arm) begin
      state <= COLLECT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
      acc_cnt <= '0;
      sample_count <= '0;
      mem_wr_addr <= BASE_W;
      mem_wr_req <= 1'b0;
      capturing <= 1'b1;
      epoch_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= conv;
        wr_ptr <= wr_ptr + 1'b1;
        acc_cnt <= acc_cnt + 12'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        sample_count <= sample_count + 12'd1;
        mem_wr_addr <= mem_wr_addr + 16'd1;
      end
      if (push_try && full && !pop) overflow <= 1'b1;
      fifo_cnt <= fifo_cnt_next;
      mem_wr_req <= fifo_cnt_next != '0;
      epoch_done <= 1'b0;
      case (state)
        COLLECT: if (push && acc_cnt == NUM_W - 12'd1) begin
          state <= DRAIN;
          capturing <= 1'b0;
        end
        DRAIN: if (pop && sample_count == NUM_W - 12'd1) begin
          state <= DONE;
          epoch_done <= 1'b1;
        end
        DONE: state <= IDLE;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_eeg_sample_ingest.sv
// tb_eeg_sample_ingest: directed scoreboard bench for eeg_sample_ingest.
module tb_eeg_sample_ingest;
  localparam int NUM = 3840;
  localparam logic [15:0] BASE = 16'd0;
  logic clk = 1'b0, rst_n = 1'b0, arm = 1'b0, sample_valid = 1'b0, mem_wr_gnt = 1'b0;
  logic [15:0] sample_data = '0;
  logic mem_wr_req, capturing, epoch_done, overflow;
  logic [15:0] mem_wr_addr;
  logic [14:0] mem_wr_data;
  logic [11:0] sample_count;
  int checks = 0, errors = 0, writes = 0, done_cnt = 0;
  logic [30:0] sb [$];
  logic [30:0] exp_wr;
  logic [15:0] exp_addr = '0;
  logic [15:0] d, d0, d1;
  logic [15:0] cv [4] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8003};
  logic [14:0] cx [4] = '{15'h0000, 15'h3FFF, 15'h4000, 15'h0001};

  always #5 clk = ~clk;

  eeg_sample_ingest #(.NUM_SAMPLES(NUM), .BASE_ADDR(0), .ADC_BITS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .sample_valid(sample_valid), .sample_data(sample_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_gnt(mem_wr_gnt), .capturing(capturing), .sample_count(sample_count),
    .epoch_done(epoch_done), .overflow(overflow)
  );

  function automatic logic [14:0] conv(input logic [15:0] s);
    logic signed [16:0] v;
    v = $signed({1'b0, s}) - 17'sd32768;
    v = v >>> 1;
    return v[14:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic a, input logic v, input logic g, input logic [15:0] dat);
    @(posedge clk);
    #1;
    arm = a;
    sample_valid = v;
    mem_wr_gnt = g;
    sample_data = dat;
  endtask

  task automatic idle(input int n, input logic g);
    repeat (n) cyc(1'b0, 1'b0, g, 16'h0);
  endtask

  task automatic expect_wr(input logic [14:0] dat);
    sb.push_back({exp_addr, dat});
    exp_addr++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_wr_req), 0);
    chk({tag, "_addr"}, 32'(mem_wr_addr), 0);
    chk({tag, "_data"}, 32'(mem_wr_data), 0);
    chk({tag, "_capt"}, 32'(capturing), 0);
    chk({tag, "_cnt"}, 32'(sample_count), 0);
    chk({tag, "_done"}, 32'(epoch_done), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (epoch_done) done_cnt++;
      if (mem_wr_req && mem_wr_gnt) begin
        writes++;
        chk("wr_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_wr = sb.pop_front();
          chk("wr_addr_data", {1'b0, mem_wr_addr, mem_wr_data}, {1'b0, exp_wr});
        end
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full epoch, one sample every 4 cycles, grant tied high; first four samples are conversion corners.
    cyc(1'b1, 1'b0, 1'b1, 16'h0);
    exp_addr = BASE;
    for (int i = 0; i < NUM; i++) begin
      d = i < 4 ? cv[i] : 16'($urandom);
      cyc(1'b0, 1'b1, 1'b1, d);
      expect_wr(i < 4 ? cx[i] : conv(d));
      if (i == 100) begin
        @(negedge clk);
        chk("capt_mid", 32'(capturing), 1);
      end
      if (i < NUM - 1) idle(3, 1'b1);
    end
    idle(1, 1'b1);
    @(negedge clk);
    chk("capt_after_last", 32'(capturing), 0);
    chk("done_early", 32'(epoch_done), 0);
    idle(1, 1'b1);
    @(negedge clk);
    chk("done_pulse", 32'(epoch_done), 1);
    chk("cnt_epoch", 32'(sample_count), NUM);
    idle(1, 1'b1);
    @(negedge clk);
    chk("done_clear", 32'(epoch_done), 0);
    chk("done_count", 32'(done_cnt), 1);
    chk("epoch_writes", 32'(writes), NUM);
    chk("epoch_sb_empty", 32'(sb.size()), 0);
    chk("epoch_ovf", 32'(overflow), 0);
    cyc(1'b0, 1'b1, 1'b1, 16'h1234);
    idle(2, 1'b1);
    @(negedge clk);
    chk("idle_ign_req", 32'(mem_wr_req), 0);
    chk("idle_ign_ovf", 32'(overflow), 0);
    chk("idle_ign_writes", 32'(writes), NUM);

    // Back-pressure: 10 samples back to back with grant low.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    exp_addr = BASE;
    d0 = 16'hA5A5;
    for (int i = 0; i < 10; i++) begin
      d = i == 0 ? d0 : 16'($urandom);
      cyc(1'b0, 1'b1, 1'b0, d);
      if (i < 4) expect_wr(conv(d));
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      chk("bp_req", 32'(mem_wr_req), 1);
      chk("bp_addr_stable", 32'(mem_wr_addr), 32'(BASE));
      chk("bp_data_stable", 32'(mem_wr_data), 32'(conv(d0)));
    end
    chk("bp_ovf", 32'(overflow), 1);
    chk("bp_cnt", 32'(sample_count), 0);
    idle(6, 1'b1);
    @(negedge clk);
    chk("bp_cnt_drain", 32'(sample_count), 4);
    chk("bp_sb_empty", 32'(sb.size()), 0);
    chk("bp_req_idle", 32'(mem_wr_req), 0);

    // Full FIFO with push and pop in the same cycle.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    exp_addr = BASE;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      if (i == 1) d1 = d;
      cyc(1'b0, 1'b1, 1'b0, d);
      expect_wr(conv(d));
    end
    d = 16'($urandom);
    cyc(1'b0, 1'b1, 1'b1, d);
    expect_wr(conv(d));
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("full_ovf", 32'(overflow), 0);
    chk("full_cnt", 32'(sample_count), 1);
    chk("full_addr", 32'(mem_wr_addr), 32'(BASE) + 1);
    chk("full_data", 32'(mem_wr_data), 32'(conv(d1)));
    idle(6, 1'b1);
    @(negedge clk);
    chk("full_cnt_drain", 32'(sample_count), 5);
    chk("full_sb_empty", 32'(sb.size()), 0);
    chk("full_ovf_end", 32'(overflow), 0);

    // Re-arm around sample 100 with the FIFO holding data and overflow set.
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    exp_addr = BASE;
    for (int i = 0; i < 99; i++) begin
      d = 16'($urandom);
      cyc(1'b0, 1'b1, 1'b1, d);
      expect_wr(conv(d));
      cyc(1'b0, 1'b0, 1'b1, 16'h0);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("rearm_pre_ovf", 32'(overflow), 1);
    chk("rearm_pre_req", 32'(mem_wr_req), 1);
    chk("rearm_pre_cnt", 32'(sample_count), 99);
    cyc(1'b1, 1'b1, 1'b0, 16'h7777);
    exp_addr = BASE;
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("rearm_req", 32'(mem_wr_req), 0);
    chk("rearm_cnt", 32'(sample_count), 0);
    chk("rearm_ovf", 32'(overflow), 0);
    chk("rearm_capt", 32'(capturing), 1);
    d = 16'h1357;
    cyc(1'b0, 1'b1, 1'b1, d);
    expect_wr(conv(d));
    idle(3, 1'b1);
    @(negedge clk);
    chk("rearm_sb_empty", 32'(sb.size()), 0);
    chk("rearm_cnt_after", 32'(sample_count), 1);

    // Asynchronous reset during DRAIN with a pending write.
    cyc(1'b1, 1'b0, 1'b1, 16'h0);
    exp_addr = BASE;
    for (int i = 0; i < NUM - 1; i++) begin
      d = 16'($urandom);
      cyc(1'b0, 1'b1, 1'b1, d);
      expect_wr(conv(d));
    end
    d = 16'($urandom);
    cyc(1'b0, 1'b1, 1'b0, d);
    expect_wr(conv(d));
    cyc(1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    chk("drain_req", 32'(mem_wr_req), 1);
    chk("drain_capt", 32'(capturing), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 16'($urandom));
    idle(1, 1'b1);
    @(negedge clk);
    chk("post_rst_req", 32'(mem_wr_req), 0);
    chk("post_rst_cnt", 32'(sample_count), 0);
    chk("post_rst_capt", 32'(capturing), 0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0);
    exp_addr = BASE;
    d = 16'h0F0F;
    cyc(1'b0, 1'b1, 1'b1, d);
    expect_wr(conv(d));
    idle(3, 1'b1);
    @(negedge clk);
    chk("post_rst_sb_empty", 32'(sb.size()), 0);
    chk("post_rst_cnt_after", 32'(sample_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/eeg_sample_ingest.md
Name: eeg_sample_ingest

Overview:
- Upstream front-end of the centralized CIM. Accepts raw ADC EEG samples, converts each to the 15-bit signed intermediate-result storage format, and writes them sequentially into intermediate-result memory starting at the EEG_INPUT_MEM region.
- Signals the controller when one full epoch of NUM_PATCHES*PATCH_LEN samples has been written, so PATCH_PROJ_STEP can start.
- A small FIFO absorbs stalls while the memory arbiter is busy.

Parameters:
- NUM_SAMPLES, 3840, samples per epoch (NUM_PATCHES*PATCH_LEN).
- BASE_ADDR, 0, intermediate-result address of the first sample (mem_map[EEG_INPUT_MEM]).
- ADC_BITS, 16, width of the unsigned ADC code.
- FIFO_DEPTH, 4, sample buffer depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  single-cycle pulse; starts or restarts capture of one epoch
- sample_valid  in  1  single-cycle strobe; a new ADC sample is present
- sample_data  in  ADC_BITS  unsigned ADC code
- mem_wr_req  out  1  write request to the intermediate-result arbiter
- mem_wr_addr  out  16  IntResAddr_t write address
- mem_wr_data  out  15  IntResSingle_t write data
- mem_wr_gnt  in  1  arbiter grant; a write occurs on a cycle with req & gnt
- capturing  out  1  high while in the COLLECT state
- sample_count  out  12  number of samples written in the current epoch
- epoch_done  out  1  one-cycle pulse after the last write of an epoch
- overflow  out  1  sticky; at least one sample was dropped

Behaviour:
- Reset: state IDLE; FIFO empty; all counters 0. All outputs are 0: mem_wr_req, mem_wr_addr, mem_wr_data, capturing, sample_count, epoch_done, overflow.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE -> COLLECT on arm.
  - COLLECT -> DRAIN when the accepted-sample count reaches NUM_SAMPLES.
  - DRAIN -> DONE on the handshake of the last write (sample_count reaches NUM_SAMPLES).
  - DONE -> IDLE unconditionally after one cycle. epoch_done = 1 only in DONE.
- arm in any state:
  - flushes the FIFO, clears the accepted count, sample_count and overflow, and drops mem_wr_req;
  - enters COLLECT on the next cycle.
  - arm has priority over every other event in the same cycle.
  - A sample_valid coinciding with arm is ignored.
- Sample acceptance: a sample is pushed only when in COLLECT, sample_valid = 1, and the accepted count < NUM_SAMPLES. sample_valid in IDLE, DRAIN or DONE is ignored and does not set overflow.
- Conversion (combinational, before push):
  - data = (sample_data - 2^(ADC_BITS-1)) >>> (ADC_BITS-15), giving a 15-bit two's-complement result.
  - Shift is arithmetic truncation, no rounding.
  - If ADC_BITS = 15 there is no shift; ADC_BITS < 15 is illegal.
- FIFO full behaviour:
  - Push while full with no pop in the same cycle drops the sample and sets overflow.
  - A dropped sample does not increment the accepted count, so the epoch still collects NUM_SAMPLES valid samples.
  - Push and pop in the same cycle while full is legal and loses nothing.
- Write port:
  - mem_wr_req is registered and is 1 whenever the FIFO head is valid.
  - mem_wr_data is the FIFO head; mem_wr_addr = BASE_ADDR + sample_count.
  - addr and data are held stable while req = 1 and gnt = 0.
  - On req & gnt: pop the FIFO and increment sample_count; the next head is presented the following cycle with no bubble if the FIFO is non-empty.
- Latency: a sample accepted at cycle t into an empty FIFO produces mem_wr_req = 1 at t+1.
- Throughput: one write per cycle when gnt is held high.
- Address arithmetic: 16-bit. BASE_ADDR + NUM_SAMPLES - 1 must be < 63488; this is checked by an elaboration assertion.
- mem_wr_gnt while mem_wr_req = 0 is ignored.
- Reset asserted mid-epoch returns the block to reset values immediately (asynchronous). The partial epoch is abandoned; memory contents are untouched.

Test Plan:
- Arm, then 3840 samples 1 per 4 cycles with gnt tied 1:
  - expect 3840 writes at addresses 0..3839;
  - capturing falls when the last sample is accepted;
  - epoch_done pulses exactly once, 2 cycles after the 3840th sample; overflow = 0.
- Conversion checks: sample_data 0x8000 -> 0x0000; 0xFFFF -> 0x3FFF; 0x0000 -> 0x4000 (-16384); 0x8003 -> 0x0001.
- Back-pressure: gnt = 0 for 10 cycles with 1 sample per cycle:
  - the first 4 samples are buffered and the next 6 dropped; overflow = 1;
  - after gnt = 1, writes resume in order at sequential addresses with addr/data stable during the stall.
- Full FIFO with simultaneous push and gnt: no drop, overflow stays 0, count increments by one.
- Re-arm at sample 100 while the FIFO is non-empty:
  - FIFO flushed, sample_count = 0, overflow cleared;
  - the next write targets BASE_ADDR; the coincident sample is ignored.
- Assert rst_n low mid-DRAIN with req = 1:
  - all outputs go to 0 asynchronously;
  - after release, sample_valid is ignored until arm.
